seq_multiplier: RTL

Sequential, parametrised N×N shift-add multiplier with a start/busy/done handshake and a per-operation signed/unsigned mode. It succeeds the single-cycle combinational multiplier. It trades latency (N+1 cycles) for one N-bit adder instead of an N×N array. It sits behind any controller that issues a start pulse and collects a 2N-bit product.

---
 rtl/seq_multiplier.sv | 93 +++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential N x N shift-add multiplier: N CALC cycles through one N-bit adder,
// signed operands handled as magnitudes with the sign reapplied at the end.
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Product
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic            load;
    logic [N-1:0]    mcand, mplier;
    logic [2*N-1:0]  acc, acc_nx;
    logic [N:0]      sum;
    logic [CW-1:0]   cnt;
    logic            neg, last;
    logic [N-1:0]    a_mag, b_mag;

    // -2^(N-1) negates to itself, which read unsigned is the correct magnitude
    assign a_mag = (is_signed && A[N-1]) ? -A : A;
    assign b_mag = (is_signed && B[N-1]) ? -B : B;

    // sum carries the adder's carry-out, which the right shift moves into acc's MSB
    assign sum    = {1'b0, acc[2*N-1:N]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign acc_nx = {sum, acc[N-1:1]};
    assign last   = (cnt == CW'(N-1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            Product <= '0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (A[N-1] ^ B[N-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_nx;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) Product <= neg ? -acc_nx : acc_nx;
        end
    end
endmodule
